// File: rtl/wordline_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : wordline_sequencer_if
// Purpose  : Request and wordline bundle between the array controller
//            (master) and the wordline sequencer (slave).
// Signals  : i_enable     - global enable; low aborts any operation
//            i_req_valid  - request valid
//            o_req_ready  - sequencer can accept a request
//            i_row_sel    - start row address, one real level per bit (LSB = 0)
//            i_burst_len  - rows in the request (0 -> 1, >MAXB -> MAXB)
//            o_row_out    - wordline levels (VDD / VSS)
//            o_pre_out    - bitline precharge level (VDD / VSS)
//            o_busy       - sequencer is not idle
//            o_done       - one-cycle pulse when a burst completes
// Revision : 1.0 - initial release
// ============================================================================
interface wordline_sequencer_if #(
  parameter int ROWS = 16,
  parameter int MAXB = 8
);
  localparam int AW = $clog2(ROWS);
  localparam int BW = $clog2(MAXB + 1);

  logic          i_enable;
  logic          i_req_valid;
  logic          o_req_ready;
  real           i_row_sel [0:AW-1];
  logic [BW-1:0] i_burst_len;
  real           o_row_out [0:ROWS-1];
  real           o_pre_out;
  logic          o_busy;
  logic          o_done;

  modport master (
    output i_enable, i_req_valid, i_row_sel, i_burst_len,
    input  o_req_ready, o_row_out, o_pre_out, o_busy, o_done
  );

  modport slave (
    input  i_enable, i_req_valid, i_row_sel, i_burst_len,
    output o_req_ready, o_row_out, o_pre_out, o_busy, o_done
  );
endinterface
`default_nettype wire

// File: rtl/wordline_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : wordline_sequencer
// Purpose  : Captures a thresholded real-valued row address and drives a
//            precharge window followed by a one-hot wordline pulse for each
//            row of a burst, wrapping from ROWS-1 to 0.
// Ports    : clk   - system clock
//            rst_n - synchronous active-low reset
//            bus   - wordline_sequencer_if.slave (request handshake, row
//                    address, burst length, wordline/precharge levels,
//                    busy, done)
// Revision : 1.0 - initial release
// ============================================================================
module wordline_sequencer #(
  parameter int  ROWS    = 16,
  parameter real VDD     = 1.5,
  parameter real VSS     = 0.0,
  parameter real VTH     = 0.8,
  parameter int  PRE_CYC = 2,
  parameter int  WL_CYC  = 4,
  parameter int  MAXB    = 8
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  wordline_sequencer_if.slave bus
);
  localparam int AW   = $clog2(ROWS);
  localparam int BW   = $clog2(MAXB + 1);
  localparam int CMAX = (PRE_CYC > WL_CYC) ? PRE_CYC : WL_CYC;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_PRE  = 2'd1;
  localparam logic [1:0] c_WL   = 2'd2;
  localparam logic [1:0] c_DONE = 2'd3;

  localparam logic [CW-1:0] c_PRE_LAST = CW'(PRE_CYC - 1);
  localparam logic [CW-1:0] c_WL_LAST  = CW'(WL_CYC - 1);
  localparam logic [BW-1:0] c_MAXB     = BW'(MAXB);
  localparam logic [BW-1:0] c_ONE      = BW'(1);

  logic [1:0]      r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt,   w_cnt_nxt;
  logic [BW-1:0]   r_rem,   w_rem_nxt;
  logic [AW-1:0]   r_addr,  w_addr_nxt;
  logic            r_pre,   w_pre_nxt;
  logic [ROWS-1:0] r_row,   w_row_nxt;
  logic            r_busy,  w_busy_nxt;
  logic            r_done,  w_done_nxt;

  logic [AW-1:0]   w_addr_in;
  logic [BW-1:0]   w_blen;
  logic            w_ready;
  logic            w_accept;

  // Address bits are decided by comparing each real input against VTH.
  for (genvar s = 0; s < AW; s++) begin : g_thr
    assign w_addr_in[s] = (bus.i_row_sel[s] >= VTH);
  end

  always_comb begin
    w_blen = bus.i_burst_len;
    if (bus.i_burst_len == '0)
      w_blen = c_ONE;
    else if (bus.i_burst_len > c_MAXB)
      w_blen = c_MAXB;
  end

  assign w_ready  = bus.i_enable && (r_state == c_IDLE);
  assign w_accept = bus.i_req_valid && w_ready;

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_addr  <= '0;
      r_pre   <= 1'b0;
      r_row   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rem   <= w_rem_nxt;
      r_addr  <= w_addr_nxt;
      r_pre   <= w_pre_nxt;
      r_row   <= w_row_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next state and datapath counters.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rem_nxt   = r_rem;
    w_addr_nxt  = r_addr;
    if (!bus.i_enable) begin
      w_state_nxt = c_IDLE;
      w_cnt_nxt   = '0;
      w_rem_nxt   = '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_accept) begin
            w_state_nxt = c_PRE;
            w_cnt_nxt   = '0;
            w_rem_nxt   = w_blen;
            w_addr_nxt  = w_addr_in;
          end
        end
        c_PRE: begin
          if (r_cnt == c_PRE_LAST) begin
            w_state_nxt = c_WL;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        c_WL: begin
          if (r_cnt == c_WL_LAST) begin
            w_cnt_nxt = '0;
            w_rem_nxt = r_rem - 1'b1;
            if (r_rem == c_ONE) begin
              w_state_nxt = c_DONE;
            end else begin
              w_state_nxt = c_PRE;
              // Power-of-two ROWS makes the natural AW-bit overflow the wrap.
              w_addr_nxt  = r_addr + 1'b1;
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = c_IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so the registered levels line up
  // with the state they belong to; PRE and WL are exclusive, so precharge and
  // the single active wordline can never overlap.
  always_comb begin
    w_pre_nxt  = (w_state_nxt == c_PRE);
    w_row_nxt  = '0;
    if (w_state_nxt == c_WL)
      w_row_nxt[w_addr_nxt] = 1'b1;
    w_busy_nxt = (w_state_nxt != c_IDLE);
    w_done_nxt = (w_state_nxt == c_DONE);
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    assign bus.o_row_out[i] = r_row[i] ? VDD : VSS;
  end

  assign bus.o_pre_out   = r_pre ? VDD : VSS;
  assign bus.o_req_ready = w_ready;
  assign bus.o_busy      = r_busy;
  assign bus.o_done      = r_done;
endmodule
`default_nettype wire

// File: tb/tb_wordline_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_wordline_sequencer
// Purpose  : Directed self-checking bench for wordline_sequencer (ROWS=16,
//            PRE_CYC=2, WL_CYC=4, MAXB=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wordline_sequencer;
  localparam int ROWS = 16;
  localparam int PRE  = 2;
  localparam int WL   = 4;
  localparam int MAXB = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wordline_sequencer_if #(.ROWS(ROWS), .MAXB(MAXB)) bus ();

  wordline_sequencer #(
    .ROWS(ROWS), .VDD(1.5), .VSS(0.0), .VTH(0.8),
    .PRE_CYC(PRE), .WL_CYC(WL), .MAXB(MAXB)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input real obs, input real exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0.3f, expected %0.3f", tag, obs, exp);
    end
  endtask

  // Index of the single wordline at VDD; -1 none, -2 several, -3 bad level.
  function automatic int active_row();
    int cnt = 0;
    int idx = -1;
    for (int i = 0; i < ROWS; i++) begin
      if (bus.o_row_out[i] != 0.0) begin
        if (bus.o_row_out[i] != 1.5) return -3;
        cnt++;
        idx = i;
      end
    end
    if (cnt > 1) return -2;
    return idx;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int row);
    for (int b = 0; b < 4; b++)
      bus.i_row_sel[b] = row[b] ? 1.5 : 0.0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_pre"},  bus.o_pre_out, 0.0);
    check({tag, "_row"},  real'(active_row()), -1.0);
    check({tag, "_busy"}, real'(bus.o_busy), 0.0);
    check({tag, "_done"}, real'(bus.o_done), 0.0);
  endtask

  // Handshake one request; row_sel is scrambled afterwards so a design that
  // keeps sampling it would show the wrong row.
  task automatic accept(input int blen);
    check("ready_before_accept", real'(bus.o_req_ready), 1.0);
    bus.i_burst_len = blen[3:0];
    bus.i_req_valid = 1'b1;
    tick();
    bus.i_req_valid = 1'b0;
    for (int b = 0; b < 4; b++) bus.i_row_sel[b] = 1.5;
  endtask

  // Called in the first cycle after accept; walks the whole burst.
  task automatic burst(input string tag, input int start, input int nrows);
    for (int r = 0; r < nrows; r++) begin
      for (int p = 0; p < PRE; p++) begin
        check({tag, "_pre_level"}, bus.o_pre_out, 1.5);
        check({tag, "_pre_norow"}, real'(active_row()), -1.0);
        check({tag, "_pre_ready"}, real'(bus.o_req_ready), 0.0);
        tick();
      end
      for (int w = 0; w < WL; w++) begin
        check({tag, "_wl_nopre"}, bus.o_pre_out, 0.0);
        check({tag, "_wl_row"},   real'(active_row()), real'((start + r) % ROWS));
        check({tag, "_wl_done"},  real'(bus.o_done), 0.0);
        tick();
      end
    end
    check({tag, "_done_pulse"}, real'(bus.o_done), 1.0);
    check({tag, "_done_busy"},  real'(bus.o_busy), 1.0);
    check({tag, "_done_pre"},   bus.o_pre_out, 0.0);
    check({tag, "_done_row"},   real'(active_row()), -1.0);
    tick();
    check_idle_outputs({tag, "_after"});
    check({tag, "_after_ready"}, real'(bus.o_req_ready), 1.0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    bus.i_enable    = 1'b1;
    bus.i_req_valid = 1'b0;
    bus.i_burst_len = '0;
    set_addr(0);
    rst_n = 1'b0;

    // Reset and idle
    repeat (3) tick();
    check_idle_outputs("in_reset");
    rst_n = 1'b1;
    tick();
    check_idle_outputs("reset_idle");
    check("reset_ready", real'(bus.o_req_ready), 1.0);

    // Single access to row 5 (LSB first: 1,0,1,0)
    bus.i_row_sel[0] = 1.5; bus.i_row_sel[1] = 0.0;
    bus.i_row_sel[2] = 1.5; bus.i_row_sel[3] = 0.0;
    accept(1);
    burst("single", 5, 1);

    // Threshold edge: 0.8 counts as 1, 0.79 as 0 -> row 1
    bus.i_row_sel[0] = 0.8; bus.i_row_sel[1] = 0.79;
    bus.i_row_sel[2] = 0.0; bus.i_row_sel[3] = 0.0;
    accept(1);
    burst("thresh", 1, 1);

    // Burst wrapping 14, 15, 0, 1
    set_addr(14);
    accept(4);
    burst("wrap", 14, 4);

    // Zero length behaves as one row; 15 clamps to MAXB
    set_addr(3);
    accept(0);
    burst("len0", 3, 1);
    set_addr(10);
    accept(15);
    burst("clamp", 10, MAXB);

    // Abort by enable during the 2nd WL cycle of a 3-row burst
    set_addr(7);
    accept(3);
    tick(); tick(); tick();
    check("en_abort_wl2_row", real'(active_row()), 7.0);
    bus.i_enable = 1'b0;
    tick();
    check_idle_outputs("en_abort");
    check("en_abort_ready_low", real'(bus.o_req_ready), 0.0);
    for (int k = 0; k < 8; k++) begin
      tick();
      check("en_abort_no_done", real'(bus.o_done), 0.0);
      check("en_abort_no_row",  real'(active_row()), -1.0);
    end
    bus.i_enable = 1'b1;
    #1;
    check("en_abort_ready_back", real'(bus.o_req_ready), 1.0);
    tick();

    // Abort by reset during the 2nd WL cycle of a 3-row burst
    set_addr(7);
    accept(3);
    tick(); tick(); tick();
    check("rst_abort_wl2_row", real'(active_row()), 7.0);
    rst_n = 1'b0;
    tick();
    check_idle_outputs("rst_abort");
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("rst_abort_no_done", real'(bus.o_done), 0.0);
      check("rst_abort_no_row",  real'(active_row()), -1.0);
    end
    check("rst_abort_ready_back", real'(bus.o_req_ready), 1.0);

    // Sequencer still works after both aborts
    set_addr(0);
    accept(1);
    burst("post_abort", 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/wordline_sequencer.md
Name: wordline_sequencer

Overview:
- Parametrised successor to the SRAM row decoder. Adds clocked wordline timing, a precharge phase, a valid/ready request handshake and a multi-row burst mode with wrap-around.
- Captures a real-valued row address and activates a one-hot real-valued wordline for a programmed pulse width, preceded by a bitline precharge window.
- Sits between the array controller and the SRAM cell rows.

Parameters:
- ROWS, 16, number of wordlines; power of two, ≥2; AW = $clog2(ROWS).
- VDD, 1.5, real high level driven on active outputs (V).
- VSS, 0.0, real low level driven on inactive outputs (V).
- VTH, 0.8, real threshold for address conversion; a bit is 1 if the input is ≥ VTH.
- PRE_CYC, 2, precharge cycles per row; ≥1.
- WL_CYC, 4, wordline-high cycles per row; ≥1.
- MAXB, 8, maximum burst length; ≥1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous, active-low reset.
- enable  input  1  global enable; low aborts any operation.
- req_valid  input  1  request valid.
- req_ready  output  1  block can accept a request.
- row_sel  input  real[0:AW-1]  start row address, one real per bit.
- burst_len  input  $clog2(MAXB+1)  rows in the request; 0 is treated as 1; values >MAXB are clamped to MAXB.
- row_out  output  real[0:ROWS-1]  wordline levels, VDD or VSS.
- pre_out  output  real  precharge level, VDD during precharge, else VSS.
- busy  output  1  high in any non-IDLE state.
- done  output  1  one-cycle pulse when a burst completes.

Behaviour:
- Reset: rst_n low at a clk edge forces state IDLE, all row_out = VSS, pre_out = VSS, busy = 0, done = 0, counters = 0. Reset mid-burst drops the wordline on the next edge and produces no done.
- req_ready = enable && state==IDLE. This is combinational from registered state.
- Accept: req_valid && req_ready at an edge.
  - Register the thresholded address: bit s = (row_sel[s] ≥ VTH).
  - Register the clamped burst count into rem.
  - Next state: PRE.
  - row_sel is sampled only at accept; later changes are ignored.
- States:
  - IDLE: all outputs low.
  - PRE:
    - pre_out = VDD and all row_out = VSS for exactly PRE_CYC cycles.
    - Then go to WL.
  - WL:
    - row_out[addr] = VDD and all other rows plus pre_out = VSS for exactly WL_CYC cycles.
    - On the last WL cycle: rem decrements.
    - If rem becomes 0, go to DONE.
    - Otherwise addr = (addr+1) mod ROWS and go to PRE. ROWS-1 wraps to 0.
  - DONE: done = 1 for one cycle, all outputs low, then IDLE.
- Break-before-make:
  - Wordline and precharge are never VDD in the same cycle.
  - At most one row_out is VDD in any cycle.
- Latency:
  - From the accept edge, pre_out rises in the next cycle.
  - The first wordline rises PRE_CYC cycles after that.
  - A burst of N rows occupies N*(PRE_CYC+WL_CYC) cycles in PRE/WL, plus 1 DONE cycle.
  - Back-to-back request: the earliest next accept is the cycle after DONE.
- All outputs are registered. row_out and pre_out are driven from registered logic through VDD/VSS mapping only.
- enable low in any state:
  - Next edge goes to IDLE, with all outputs VSS and no done.
  - enable has lower priority than rst_n.
- req_valid while busy is ignored because req_ready = 0; there is no queueing.

Test Plan:
- Reset and idle:
  - Stimulus: hold rst_n=0 for 3 cycles, then release.
  - Required: all row_out = 0.0, pre_out = 0.0, busy = 0, req_ready = 1 with enable = 1.
- Single access, ROWS=16, PRE_CYC=2, WL_CYC=4:
  - Stimulus: row_sel = {1.5,0,1.5,0} (LSB first → row 5), burst_len = 1.
  - Required: pre_out = 1.5 for 2 cycles, then row_out[5] = 1.5 for 4 cycles, then done pulse. Total 7 cycles after accept; no overlap.
- Threshold edge:
  - Stimulus: row_sel bits = {0.8, 0.79, 0, 0}.
  - Required: row 1 activates, because 0.8 counts as 1 and 0.79 counts as 0.
- Burst with wrap:
  - Stimulus: start row 14, burst_len = 4.
  - Required: wordlines fire in order 14, 15, 0, 1. Each is preceded by a 2-cycle precharge. A single done arrives after 24 cycles of PRE/WL.
- Clamp and zero length:
  - Stimulus: burst_len = 0, then burst_len = 15 with MAXB = 8.
  - Required: 1 row, then 8 rows activated.
- Abort:
  - Stimulus: deassert enable, then separately pull rst_n low, each during the 2nd WL cycle of a 3-row burst.
  - Required: all outputs = 0.0 on the next edge, no done, and req_ready returns to 1 once enable = 1 and rst_n = 1.
